rv_fetch_unit: RTL and testbench
================================

// Module: rv_fetch_unit
// PURPOSE
//  Instruction fetch front-end for the pipelined core; sits upstream of decode and the hazard/flush controller.
//  Generates the sequential PC, drives a req/ack instruction bus, buffers returned words with their PC.
//  Presents {pc, instr} to decode. Honours stall (hold) and redirect (flush + new PC) from the controller.
//  Reports o_fetch_ack (instruction available) back to the controller.
// PARAMETERS
//  RESET_ADDR  32'h0000_0000  PC of the first fetch after reset
//  DEPTH       2              prefetch buffer entries (power of 2, >=2)
// PORTS
//  i_clk          in   1   clock, all state on posedge
//  i_reset_n      in   1   synchronous active-low reset
//  i_stall        in   1   hold the decode-facing entry (controller fetch stall)
//  i_pc_sel       in   1   redirect: branch/jump taken in execute
//  i_pc_target    in   32  redirect target (bits[1:0] ignored, forced 0)
//  o_bus_req      out  1   instruction bus request; held until i_bus_ack
//  o_bus_addr     out  32  word address; stable while o_bus_req && !i_bus_ack
//  i_bus_ack      in   1   read data valid this cycle, completes request
//  i_bus_data     in   32  instruction word
//  o_valid        out  1   buffer head valid
//  o_instr        out  32  head instruction; NOP (32'h0000_0013) when !o_valid
//  o_pc           out  32  PC of head instruction
//  o_pc_plus4     out  32  o_pc + 4, modulo 2^32
//  o_fetch_ack    out  1   = o_valid; feeds controller i_fetch_bus_ack
// BEHAVIOUR
//  Reset: fetch PC=RESET_ADDR, o_bus_req=0, buffer empty, o_valid=0, o_instr=NOP, o_pc=RESET_ADDR, FSM=IDLE.
//  At most one outstanding bus request. FSM states:
//   IDLE:    issue when (count + 0) < DEPTH and !i_pc_sel -> REQ, o_bus_addr=fetch PC.
//   REQ:     on i_bus_ack & !i_pc_sel: push {addr,data}, fetch PC+=4; issue next same cycle if space remains after
//            this cycle's push/pop, else IDLE. On i_pc_sel (with or without ack): flush, fetch PC=target;
//            ack present -> IDLE (data dropped); ack absent -> DISCARD.
//   DISCARD: keep o_bus_req=1, same addr, until i_bus_ack; drop data -> IDLE. Further i_pc_sel updates target only.
//  Pop: head leaves when o_valid && !i_stall && !i_pc_sel. Push and pop same cycle: count unchanged.
//  Full (count==DEPTH): no issue; hold IDLE. Empty: o_valid=0, o_instr=NOP.
//  Redirect flushes the whole buffer in the same cycle; redirect beats pop and push.
//  Latency: ack in cycle N -> o_valid in N+1. Redirect in N -> req at target no earlier than N+1.
//  Redirect while in IDLE: flush, new PC; request issued in N+1.
//  Fetch PC wraps 32'hFFFF_FFFC -> 0 without error.
//  Reset asserted mid-request: bus request dropped immediately; a late ack after reset is ignored (state IDLE,
//   buffer empty, ack only accepted in REQ/DISCARD).
// STRUCTURE
//  rv_pkg: RV_NOP constant, fetch_entry_t typedef {logic[31:0] pc; logic[31:0] instr;}, fetch_state_e {IDLE,REQ,DISCARD}.
//  Sub-module rv_fetch_fifo: DEPTH x fetch_entry_t, push/pop/flush, count, wrap-around pointers.
//   Flush has priority over push.
//  Top: FSM, fetch PC register, issue logic, output muxing.
// TESTING
//  1. Reset release, bus acks every cycle -> req addrs 0,4,8,...; o_valid from cycle 2, o_pc increments by 4.
//  2. i_stall held 5 cycles, acks zero-wait -> o_pc/o_instr frozen; buffer fills to 2, o_bus_req drops;
//     resumes on release.
//  3. Redirect to 32'h100 while REQ pending (ack 3 cycles later) -> DISCARD; stale data never reaches o_instr;
//     next addr 32'h100.
//  4. Redirect coincident with ack and with pop -> buffer empty next cycle, o_valid=0; next req at target.
//  5. Start at RESET_ADDR=32'hFFFF_FFF8 -> addrs FFF8, FFFC, 0000_0000; o_pc_plus4 of FFFC = 0.
//  6. Reset during pending req, bus acks one cycle later -> ack ignored, o_valid=0; first new req at RESET_ADDR.

Source files
------------

// File: rtl/rv_pkg.sv
// ---------------------------------------------------------------------------
// rv_pkg
// Shared types and constants for the instruction fetch front-end.
//   RV_NOP         canonical NOP (addi x0, x0, 0) shown to decode when empty
//   fetch_entry_t  one prefetch buffer entry: {pc, instr}
//   fetch_state_e  bus-side FSM states
//   word_align     clears the byte-offset bits of an address
// ---------------------------------------------------------------------------
package rv_pkg;

  localparam logic [31:0] RV_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

  // Instructions are word aligned; the low two bits of any target are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/rv_fetch_fifo.sv
// ---------------------------------------------------------------------------
// rv_fetch_fifo
// Small prefetch buffer holding fetched {pc, instr} pairs in order.
// Ports:
//   i_clk, i_reset_n   clock, synchronous active-low reset
//   i_push             write i_push_entry at the tail
//   i_push_entry       entry to write
//   i_pop              drop the head entry
//   i_flush            empty the buffer; wins over push and pop
//   o_head             current head entry (combinational read)
//   o_count            number of valid entries, 0..DEPTH
//   o_empty, o_full    occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module rv_fetch_fifo
  import rv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic                     i_push,
  input  fetch_entry_t             i_push_entry,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output fetch_entry_t             o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_empty,
  output logic                     o_full
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t      entry_mem [DEPTH];
  logic [AW-1:0]     rd_ptr_reg;
  logic [AW-1:0]     rd_ptr_next;
  logic [AW-1:0]     wr_ptr_reg;
  logic [AW-1:0]     wr_ptr_next;
  logic [AW:0]       count_reg;
  logic [AW:0]       count_next;
  logic              push_eff;
  logic              pop_eff;
  logic [DEPTH-1:0]  wr_en;

  assign o_empty = (count_reg == '0);
  assign o_full  = (count_reg == (AW+1)'(DEPTH));
  assign o_count = count_reg;

  // Pop only a real entry; a push into a full buffer is allowed only when
  // the head leaves in the same cycle.
  assign pop_eff  = i_pop && !i_flush && !o_empty;
  assign push_eff = i_push && !i_flush && (!o_full || pop_eff);

  genvar gi;
  for (gi = 0; gi < DEPTH; gi++) begin : g_wr_en
    assign wr_en[gi] = push_eff && (wr_ptr_reg == AW'(gi));
  end

  // Storage is not reset: occupancy is tracked by count_reg alone.
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_en[i]) begin
        entry_mem[i] <= i_push_entry;
      end
    end
  end

  // Head must be visible the cycle after the push, so the read is direct.
  assign o_head = entry_mem[rd_ptr_reg];

  always_comb begin
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    count_next  = count_reg;
    if (i_flush) begin
      rd_ptr_next = '0;
      wr_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push_eff) begin
        wr_ptr_next = wr_ptr_reg + AW'(1);
      end
      if (pop_eff) begin
        rd_ptr_next = rd_ptr_reg + AW'(1);
      end
      case ({push_eff, pop_eff})
        2'b10:   count_next = count_reg + (AW+1)'(1);
        2'b01:   count_next = count_reg - (AW+1)'(1);
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      count_reg  <= count_next;
    end
  end

endmodule

// File: rtl/rv_fetch_unit.sv
// ---------------------------------------------------------------------------
// rv_fetch_unit
// Instruction fetch front-end: sequential PC generation, single-outstanding
// req/ack instruction bus, prefetch buffer, stall and redirect handling.
// Ports:
//   i_clk, i_reset_n   clock, synchronous active-low reset
//   i_stall            hold the decode-facing entry
//   i_pc_sel           redirect (flush + new PC) from execute
//   i_pc_target        redirect target, low two bits ignored
//   o_bus_req          bus request, held until i_bus_ack
//   o_bus_addr         word address of the outstanding request
//   i_bus_ack          read data valid, completes the request
//   i_bus_data         instruction word
//   o_valid            buffer head valid
//   o_instr            head instruction, NOP when empty
//   o_pc, o_pc_plus4   PC of head and PC + 4 (mod 2^32)
//   o_fetch_ack        same as o_valid, for the hazard controller
// ---------------------------------------------------------------------------
module rv_fetch_unit
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int          DEPTH      = 2
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_stall,
  input  logic        i_pc_sel,
  input  logic [31:0] i_pc_target,
  output logic        o_bus_req,
  output logic [31:0] o_bus_addr,
  input  logic        i_bus_ack,
  input  logic [31:0] i_bus_data,
  output logic        o_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_plus4,
  output logic        o_fetch_ack
);

  localparam int CW = $clog2(DEPTH) + 1;

  localparam logic [1:0] ST_IDLE    = IDLE;
  localparam logic [1:0] ST_REQ     = REQ;
  localparam logic [1:0] ST_DISCARD = DISCARD;

  logic [1:0]    state_reg;
  logic [1:0]    state_next;
  // fetch_pc_reg: address of the next request to issue.
  // bus_addr_reg: address of the request currently on the bus.
  logic [31:0]   fetch_pc_reg;
  logic [31:0]   fetch_pc_next;
  logic [31:0]   bus_addr_reg;
  logic [31:0]   bus_addr_next;

  logic [31:0]   target_aligned;
  logic          fifo_push;
  logic          fifo_pop;
  fetch_entry_t  push_entry;
  fetch_entry_t  head_entry;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic          fifo_full;
  logic [CW:0]   count_after;
  logic          room_after;
  logic [31:0]   pc_out;

  assign target_aligned = word_align(i_pc_target);

  // Redirect beats both pop and push.
  assign fifo_pop   = !fifo_empty && !i_stall && !i_pc_sel;
  assign fifo_push  = (state_reg == ST_REQ) && i_bus_ack && !i_pc_sel;
  assign push_entry = '{pc: bus_addr_reg, instr: i_bus_data};

  // Occupancy once this cycle's push and pop have landed; decides whether the
  // next request can go out back-to-back with the ack.
  assign count_after = {1'b0, fifo_count}
                     + {{CW{1'b0}}, fifo_push}
                     - {{CW{1'b0}}, fifo_pop};
  assign room_after  = (count_after < (CW+1)'(DEPTH));

  rv_fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk        (i_clk),
    .i_reset_n    (i_reset_n),
    .i_push       (fifo_push),
    .i_push_entry (push_entry),
    .i_pop        (fifo_pop),
    .i_flush      (i_pc_sel),
    .o_head       (head_entry),
    .o_count      (fifo_count),
    .o_empty      (fifo_empty),
    .o_full       (fifo_full)
  );

  always_comb begin
    state_next    = state_reg;
    fetch_pc_next = fetch_pc_reg;
    bus_addr_next = bus_addr_reg;
    case (state_reg)
      ST_IDLE: begin
        if (i_pc_sel) begin
          fetch_pc_next = target_aligned;
        end else if (!fifo_full) begin
          bus_addr_next = fetch_pc_reg;
          fetch_pc_next = fetch_pc_reg + 32'd4;
          state_next    = ST_REQ;
        end
      end
      ST_REQ: begin
        if (i_pc_sel) begin
          // The in-flight word is stale. If it has already arrived it is
          // simply not pushed; otherwise wait it out in DISCARD.
          fetch_pc_next = target_aligned;
          state_next    = i_bus_ack ? ST_IDLE : ST_DISCARD;
        end else if (i_bus_ack) begin
          if (room_after) begin
            bus_addr_next = fetch_pc_reg;
            fetch_pc_next = fetch_pc_reg + 32'd4;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      ST_DISCARD: begin
        // Bus address stays put until the stale request completes; later
        // redirects only move the restart point.
        if (i_pc_sel) begin
          fetch_pc_next = target_aligned;
        end
        if (i_bus_ack) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_reg    <= ST_IDLE;
      fetch_pc_reg <= RESET_ADDR;
      bus_addr_reg <= RESET_ADDR;
    end else begin
      state_reg    <= state_next;
      fetch_pc_reg <= fetch_pc_next;
      bus_addr_reg <= bus_addr_next;
    end
  end

  // Request is gated by reset so it drops in the cycle reset is asserted
  // rather than one clock later.
  assign o_bus_req  = i_reset_n && ((state_reg == ST_REQ) || (state_reg == ST_DISCARD));
  assign o_bus_addr = bus_addr_reg;

  // With an empty buffer the PC shown is where fetching is heading.
  assign pc_out      = fifo_empty ? fetch_pc_reg : head_entry.pc;
  assign o_valid     = !fifo_empty;
  assign o_fetch_ack = !fifo_empty;
  assign o_instr     = fifo_empty ? RV_NOP : head_entry.instr;
  assign o_pc        = pc_out;
  assign o_pc_plus4  = pc_out + 32'd4;

endmodule

// File: tb/tb_rv_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_rv_fetch_unit
// Scoreboard bench: stimulus pushes expected bus addresses and expected
// decode-side {pc, instr} pairs into queues; a monitor pops and compares on
// every bus ack and every head pop. The DUT starts at 32'hFFFF_FFF8 so the
// PC wrap through zero is part of the normal sequential stream.
// ---------------------------------------------------------------------------
module tb_rv_fetch_unit;
  import rv_pkg::*;

  localparam logic [31:0] START = 32'hFFFF_FFF8;

  logic        clk;
  logic        reset_n;
  logic        stall;
  logic        pc_sel;
  logic [31:0] pc_target;
  logic        bus_req;
  logic [31:0] bus_addr;
  logic        bus_ack;
  logic [31:0] bus_data;
  logic        valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_ack;

  int check_cnt = 0;
  int pass_cnt  = 0;
  int pops_done = 0;
  int ack_delay = 0;
  logic force_ack = 1'b0;

  logic [31:0]  exp_addr_q [$];
  fetch_entry_t exp_instr_q [$];

  rv_fetch_unit #(
    .RESET_ADDR (START),
    .DEPTH      (2)
  ) dut (
    .i_clk       (clk),
    .i_reset_n   (reset_n),
    .i_stall     (stall),
    .i_pc_sel    (pc_sel),
    .i_pc_target (pc_target),
    .o_bus_req   (bus_req),
    .o_bus_addr  (bus_addr),
    .i_bus_ack   (bus_ack),
    .i_bus_data  (bus_data),
    .o_valid     (valid),
    .o_instr     (instr),
    .o_pc        (pc),
    .o_pc_plus4  (pc_plus4),
    .o_fetch_ack (fetch_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents: a distinct word per address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Expected sequential stream starting at 'start' (32-bit wrap included).
  task automatic fill(input logic [31:0] start, input int n);
    logic [31:0] a;
    for (int k = 0; k < n; k++) begin
      a = start + 32'(4 * k);
      exp_addr_q.push_back(a);
      exp_instr_q.push_back('{pc: a, instr: mem_word(a)});
    end
  endtask

  task automatic clear_q();
    exp_addr_q.delete();
    exp_instr_q.delete();
  endtask

  // Inputs change 3 time units after the active edge.
  task automatic cyc();
    @(posedge clk);
    #3;
  endtask

  task automatic wait_pops(input int n, input int budget);
    int target;
    target = pops_done + n;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (pops_done >= target) break;
    end
    chk("wait_pops", 32'(pops_done >= target), 32'h1);
  endtask

  // Bus slave: acks after ack_delay waiting cycles; force_ack injects an ack
  // regardless of request (used for the late-ack-after-reset case).
  initial begin : responder
    int wait_cnt;
    wait_cnt = 0;
    bus_ack  = 1'b0;
    bus_data = '0;
    forever begin
      @(posedge clk);
      #1;
      if (force_ack) begin
        bus_ack  = 1'b1;
        bus_data = 32'hDEAD_BEEF;
        wait_cnt = 0;
      end else if (bus_req) begin
        if (wait_cnt >= ack_delay) begin
          bus_ack  = 1'b1;
          bus_data = mem_word(bus_addr);
          wait_cnt = 0;
        end else begin
          bus_ack  = 1'b0;
          wait_cnt++;
        end
      end else begin
        bus_ack  = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  // Monitor: one line per bus transaction and per decode pop.
  initial begin : monitor
    logic [31:0]  ea;
    fetch_entry_t ee;
    forever begin
      @(negedge clk);
      if (bus_req && bus_ack) begin
        if (exp_addr_q.size() == 0) begin
          chk("bus_ack_expected", 32'h0, 32'h1);
        end else begin
          ea = exp_addr_q.pop_front();
          $display("bus ack  addr=%h data=%h", bus_addr, bus_data);
          chk("bus_addr", bus_addr, ea);
        end
      end
      if (reset_n && valid && !stall && !pc_sel) begin
        if (exp_instr_q.size() == 0) begin
          chk("pop_expected", 32'h0, 32'h1);
        end else begin
          ee = exp_instr_q.pop_front();
          $display("pop      pc=%h instr=%h pc+4=%h", pc, instr, pc_plus4);
          chk("pop_pc", pc, ee.pc);
          chk("pop_instr", instr, ee.instr);
          chk("pop_pc_plus4", pc_plus4, ee.pc + 32'd4);
          chk("pop_fetch_ack", 32'(fetch_ack), 32'h1);
        end
        pops_done++;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int found;
    reset_n   = 1'b0;
    stall     = 1'b0;
    pc_sel    = 1'b0;
    pc_target = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #3;
    @(negedge clk);
    chk("rst_bus_req", 32'(bus_req), 32'h0);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_instr_nop", instr, RV_NOP);
    chk("rst_pc", pc, START);
    chk("rst_pc_plus4", pc_plus4, 32'hFFFF_FFFC);
    chk("rst_fetch_ack", 32'(fetch_ack), 32'h0);

    // 1/5: zero-wait stream from FFFF_FFF8, wrapping through 0
    fill(START, 40);
    cyc();
    reset_n = 1'b1;
    @(negedge clk);
    chk("s1_c0_valid", 32'(valid), 32'h0);
    @(negedge clk);
    chk("s1_c1_valid", 32'(valid), 32'h0);
    chk("s1_c1_req", 32'(bus_req), 32'h1);
    @(negedge clk);
    chk("s1_c2_valid", 32'(valid), 32'h1);
    chk("s1_c2_pc", pc, START);
    wait_pops(6, 20);

    // 2: stall for 5 cycles, buffer fills, request drops, then resumes
    cyc();
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i != 0) cyc();
      @(negedge clk);
      chk("s2_valid", 32'(valid), 32'h1);
      if (exp_instr_q.size() != 0) begin
        chk("s2_frozen_pc", pc, exp_instr_q[0].pc);
        chk("s2_frozen_instr", instr, exp_instr_q[0].instr);
      end else begin
        chk("s2_queue_nonempty", 32'h0, 32'h1);
      end
      if (i != 0) chk("s2_req_dropped", 32'(bus_req), 32'h0);
    end
    cyc();
    stall = 1'b0;
    wait_pops(4, 20);

    // 3: redirect while a slow request is pending -> DISCARD
    cyc();
    stall = 1'b1;
    repeat (4) cyc();
    @(negedge clk);
    chk("s3_full_valid", 32'(valid), 32'h1);
    chk("s3_full_req", 32'(bus_req), 32'h0);
    clear_q();
    ack_delay = 3;
    cyc();                                  // A: redirect from IDLE
    pc_sel    = 1'b1;
    pc_target = 32'h0000_0202;
    cyc();                                  // A+1
    pc_sel = 1'b0;
    exp_addr_q.push_back(32'h0000_0200);    // stale request, data dropped
    fill(32'h0000_0100, 20);
    @(negedge clk);
    chk("s3_flush_valid", 32'(valid), 32'h0);
    chk("s3_idle_req", 32'(bus_req), 32'h0);
    cyc();                                  // A+2
    @(negedge clk);
    chk("s3_req", 32'(bus_req), 32'h1);
    chk("s3_req_addr", bus_addr, 32'h0000_0200);
    cyc();                                  // A+3: redirect while pending
    pc_sel    = 1'b1;
    pc_target = 32'h0000_0404;
    stall     = 1'b0;
    cyc();                                  // A+4: DISCARD, retarget
    pc_target = 32'h0000_0103;
    @(negedge clk);
    chk("s3_discard_req", 32'(bus_req), 32'h1);
    chk("s3_discard_addr", bus_addr, 32'h0000_0200);
    chk("s3_discard_valid", 32'(valid), 32'h0);
    chk("s3_discard_instr", instr, RV_NOP);
    cyc();                                  // A+5: stale ack arrives
    pc_sel = 1'b0;
    @(negedge clk);
    chk("s3_stale_addr", bus_addr, 32'h0000_0200);
    chk("s3_stale_ack", 32'(bus_ack), 32'h1);
    cyc();                                  // A+6
    @(negedge clk);
    chk("s3_after_valid", 32'(valid), 32'h0);
    cyc();                                  // A+7
    @(negedge clk);
    chk("s3_target_req", 32'(bus_req), 32'h1);
    chk("s3_target_addr", bus_addr, 32'h0000_0100);
    wait_pops(3, 60);

    // 4: redirect coincident with ack and with a pop
    ack_delay = 0;
    wait_pops(3, 30);
    found = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (valid && bus_ack) begin
        found = 1;
        break;
      end
    end
    chk("s4_found_ack_pop", 32'(found), 32'h1);
    pc_sel    = 1'b1;
    pc_target = 32'h0000_0300;
    cyc();                                  // B+1
    pc_sel = 1'b0;
    clear_q();
    fill(32'h0000_0300, 20);
    @(negedge clk);
    chk("s4_flush_valid", 32'(valid), 32'h0);
    chk("s4_flush_req", 32'(bus_req), 32'h0);
    cyc();                                  // B+2
    @(negedge clk);
    chk("s4_req", 32'(bus_req), 32'h1);
    chk("s4_req_addr", bus_addr, 32'h0000_0300);
    chk("s4_c2_valid", 32'(valid), 32'h0);
    cyc();                                  // B+3
    @(negedge clk);
    chk("s4_c3_valid", 32'(valid), 32'h1);
    chk("s4_c3_pc", pc, 32'h0000_0300);
    wait_pops(3, 20);

    // 6: reset during a pending request; late ack must be ignored
    ack_delay = 5;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (bus_req && !bus_ack) begin
        found = 1;
        break;
      end
    end
    chk("s6_found_pending", 32'(found), 32'h1);
    reset_n   = 1'b0;
    force_ack = 1'b1;
    @(negedge clk);
    chk("s6_req_dropped", 32'(bus_req), 32'h0);
    cyc();                                  // C+1: late ack on the bus
    reset_n   = 1'b1;
    force_ack = 1'b0;
    ack_delay = 0;
    clear_q();
    fill(START, 20);
    @(negedge clk);
    chk("s6_late_ack_seen", 32'(bus_ack), 32'h1);
    chk("s6_c1_valid", 32'(valid), 32'h0);
    chk("s6_c1_req", 32'(bus_req), 32'h0);
    cyc();                                  // C+2
    @(negedge clk);
    chk("s6_c2_req", 32'(bus_req), 32'h1);
    chk("s6_c2_addr", bus_addr, START);
    chk("s6_c2_valid", 32'(valid), 32'h0);
    cyc();                                  // C+3
    @(negedge clk);
    chk("s6_c3_valid", 32'(valid), 32'h1);
    chk("s6_c3_pc", pc, START);
    chk("s6_c3_instr", instr, mem_word(START));
    wait_pops(4, 20);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
